// File: rtl/mii_net_rx_fcs_check.sv
// Purpose: MII receive framer; strips preamble/SFD, assembles bytes, checks CRC-32, emits payload without FCS.
// Latency: payload byte k-5 leaves the cycle after byte k completes; the last beat and status come the cycle after rx_dv falls.
// Backpressure: none; the downstream must accept every beat (at most one beat per two cycles).
//
// Ports:
//   i_clk, i_reset         MII rx clock, synchronous active-high reset
//   i_rx_dv, i_rx_er       MII receive data valid / receive error
//   i_rxd[3:0]             MII receive nibble, low nibble of each byte first
//   o_data[7:0], o_valid   payload byte strobe (FCS never appears)
//   o_last                 qualifies o_valid; final payload byte of the frame
//   o_good, o_bad          one-cycle frame verdict, one per frame that reached DATA
module mii_net_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic       i_rx_er,
  input  logic [3:0] i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last,
  output logic       o_good,
  output logic       o_bad
);

  localparam int             CW       = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0]  MIN_C    = CW'(MIN_LEN);
  localparam logic [CW-1:0]  MAX_C    = CW'(MAX_LEN);
  localparam logic [CW-1:0]  FCS_LEN  = CW'(5);
  localparam logic [31:0]    POLY     = 32'hEDB88320;
  localparam logic [31:0]    RESIDUE  = 32'hDEBB20E3;
  localparam logic [31:0]    CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     crc, crc_nxt;
  logic            phase, phase_nxt;
  logic [3:0]      lo_nib, lo_nib_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            err, err_nxt;
  // Delay line: element 0 is the oldest byte. Holding 4 bytes behind the
  // newest lets the FCS be dropped without knowing the frame length upfront.
  logic [4:0][7:0] line, line_nxt;
  logic [7:0]      data_nxt;
  logic            valid_nxt, last_nxt, good_nxt, bad_nxt;
  logic [7:0]      byte_c;
  logic [31:0]     crc_byte;

  // Bit-serial form of the reflected table update: table[crc[7:0]^b] ^ (crc>>8).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign byte_c   = {i_rxd, lo_nib};
  assign crc_byte = crc_upd(crc, byte_c);

  always_comb begin
    state_nxt  = state;
    crc_nxt    = crc;
    phase_nxt  = phase;
    lo_nib_nxt = lo_nib;
    cnt_nxt    = cnt;
    err_nxt    = err;
    line_nxt   = line;
    data_nxt   = 8'h00;
    valid_nxt  = 1'b0;
    last_nxt   = 1'b0;
    good_nxt   = 1'b0;
    bad_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_dv) state_nxt = (i_rxd == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!i_rx_dv) begin
          state_nxt = IDLE;
        end else if (i_rxd == 4'hD) begin
          state_nxt = DATA;
          crc_nxt   = CRC_INIT;
          phase_nxt = 1'b0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          line_nxt  = '0;
        end else if (i_rxd != 4'h5) begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (!i_rx_dv) begin
          if (cnt >= FCS_LEN) begin
            valid_nxt = 1'b1;
            last_nxt  = 1'b1;
            data_nxt  = line[0];
          end
          if (crc == RESIDUE && !err && !phase && cnt >= MIN_C && cnt <= MAX_C)
            good_nxt = 1'b1;
          else
            bad_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          if (i_rx_er) err_nxt = 1'b1;
          if (!phase) begin
            lo_nib_nxt = i_rxd;
            phase_nxt  = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (cnt == MAX_C) begin
              // Oversize: close the frame early with the oldest byte as its last beat.
              cnt_nxt   = MAX_C + CW'(1);
              valid_nxt = 1'b1;
              last_nxt  = 1'b1;
              bad_nxt   = 1'b1;
              data_nxt  = line[0];
              state_nxt = DROP;
            end else begin
              crc_nxt  = crc_byte;
              cnt_nxt  = cnt + CW'(1);
              line_nxt = {byte_c, line[4:1]};
              // Line is full once five bytes have entered.
              if (cnt >= FCS_LEN) begin
                valid_nxt = 1'b1;
                data_nxt  = line[0];
              end
            end
          end
        end
      end
      DROP: begin
        if (!i_rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      crc     <= CRC_INIT;
      phase   <= 1'b0;
      lo_nib  <= 4'h0;
      cnt     <= '0;
      err     <= 1'b0;
      line    <= '0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_good  <= 1'b0;
      o_bad   <= 1'b0;
    end else begin
      state   <= state_nxt;
      crc     <= crc_nxt;
      phase   <= phase_nxt;
      lo_nib  <= lo_nib_nxt;
      cnt     <= cnt_nxt;
      err     <= err_nxt;
      line    <= line_nxt;
      o_data  <= data_nxt;
      o_valid <= valid_nxt;
      o_last  <= last_nxt;
      o_good  <= good_nxt;
      o_bad   <= bad_nxt;
    end
  end

endmodule

// File: tb/tb_mii_net_rx_fcs_check.sv
// Purpose: checks mii_net_rx_fcs_check with directed and random frames against a frame-level reference.
// Latency: each expected beat carries the cycle it must appear in.
// Backpressure: none; every output beat is logged by a monitor.
module tb_mii_net_rx_fcs_check;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic       er;
  logic [3:0] rxd;
  logic [7:0] o_data  [3];
  logic       o_valid [3];
  logic       o_last  [3];
  logic       o_good  [3];
  logic       o_bad   [3];

  int mins [3] = '{64, 13, 13};
  int maxs [3] = '{1518, 1518, 20};

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int fall_cyc;
  int hi_cyc[$];

  // record: {stamp[31:0], valid, last, good, bad, data[7:0]}
  logic [43:0] mon_q [3][$];
  logic [43:0] exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mii_net_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) u_def (
    .i_clk(clk), .i_reset(rst), .i_rx_dv(dv), .i_rx_er(er), .i_rxd(rxd),
    .o_data(o_data[0]), .o_valid(o_valid[0]), .o_last(o_last[0]), .o_good(o_good[0]), .o_bad(o_bad[0]));
  mii_net_rx_fcs_check #(.MIN_LEN(13), .MAX_LEN(1518)) u_min13 (
    .i_clk(clk), .i_reset(rst), .i_rx_dv(dv), .i_rx_er(er), .i_rxd(rxd),
    .o_data(o_data[1]), .o_valid(o_valid[1]), .o_last(o_last[1]), .o_good(o_good[1]), .o_bad(o_bad[1]));
  mii_net_rx_fcs_check #(.MIN_LEN(13), .MAX_LEN(20)) u_max20 (
    .i_clk(clk), .i_reset(rst), .i_rx_dv(dv), .i_rx_er(er), .i_rxd(rxd),
    .o_data(o_data[2]), .o_valid(o_valid[2]), .o_last(o_last[2]), .o_good(o_good[2]), .o_bad(o_bad[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_valid[i] === 1'b1 || o_good[i] === 1'b1 || o_bad[i] === 1'b1)
        mon_q[i].push_back({32'(cyc), o_valid[i], o_last[i], o_good[i], o_bad[i],
                            o_valid[i] ? o_data[i] : 8'h00});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {24'h0, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // A frame is intact when its trailing 4 bytes are the CRC of the rest, LSB first.
  function automatic bit fcs_ok(input bq_t b);
    int l;
    l = b.size();
    if (l < 4) return 1'b0;
    return crc32(b, l - 4) == {b[l-1], b[l-2], b[l-3], b[l-4]};
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t b;
    logic [31:0] c;
    b = p;
    c = crc32(p, p.size());
    b.push_back(c[7:0]);
    b.push_back(c[15:8]);
    b.push_back(c[23:16]);
    b.push_back(c[31:24]);
    return b;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t b;
    for (int k = 0; k < n; k++) b.push_back(8'($urandom));
    return b;
  endfunction

  // Expected outputs of one frame for each parameter set.
  task automatic model(input bq_t b, input bit err, input bit drib);
    int l;
    bit good;
    bit last;
    int st;
    l = b.size();
    for (int i = 0; i < 3; i++) begin
      if (l > maxs[i]) begin
        for (int j = 0; j <= maxs[i] - 5; j++) begin
          last = (j == maxs[i] - 5);
          exp_q[i].push_back({32'(hi_cyc[j+5] + 1), 1'b1, last, 1'b0, last, b[j]});
        end
      end else begin
        good = !err && !drib && l >= mins[i] && fcs_ok(b);
        if (l >= 5) begin
          for (int j = 0; j <= l - 5; j++) begin
            last = (j == l - 5);
            st   = last ? fall_cyc + 1 : hi_cyc[j+5] + 1;
            exp_q[i].push_back({32'(st), 1'b1, last, last & good, last & !good, b[j]});
          end
        end else begin
          exp_q[i].push_back({32'(fall_cyc + 1), 1'b0, 1'b0, good, !good, 8'h00});
        end
      end
    end
  endtask

  task automatic drive(input logic [3:0] nib, input logic e);
    dv  = 1'b1;
    rxd = nib;
    er  = e;
    @(negedge clk);
  endtask

  task automatic check_outs_zero(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_u%0d", tag, i),
            {o_data[i], o_valid[i], o_last[i], o_good[i], o_bad[i]}, 64'h0);
  endtask

  // kind: 0 normal, 1 junk first nibble, 2 preamble only. rst_nib: data nibble index to reset on (-1 none).
  task automatic send_frame(input bq_t b, input int er_idx, input bit drib, input int kind, input int rst_nib);
    int n;
    bit was_rst;
    n = 0;
    was_rst = 1'b0;
    hi_cyc.delete();
    if (kind == 1) drive(4'hA, 1'b0);
    for (int k = 0; k < 15; k++) drive(4'h5, 1'b0);
    if (kind != 2) begin
      drive(4'hD, 1'b0);
      for (int k = 0; k < b.size(); k++) begin
        for (int h = 0; h < 2; h++) begin
          rst = (n == rst_nib);
          if (h == 1) hi_cyc.push_back(cyc);
          drive(h ? b[k][7:4] : b[k][3:0], k == er_idx);
          if (rst) begin
            rst = 1'b0;
            was_rst = 1'b1;
            check_outs_zero("reset_outs");
          end
          n++;
        end
      end
      if (drib) drive(4'($urandom), 1'b0);
    end
    dv  = 1'b0;
    rxd = 4'($urandom);
    er  = 1'($urandom);
    fall_cyc = cyc;
    @(negedge clk);
    er = 1'b0;
    if (kind == 0 && !was_rst) model(b, er_idx >= 0 && er_idx < b.size(), drib);
  endtask

  task automatic idle(input int n);
    dv = 1'b0;
    er = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    int m;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_u%0d_count", tag, i), mon_q[i].size(), exp_q[i].size());
      m = mon_q[i].size() < exp_q[i].size() ? mon_q[i].size() : exp_q[i].size();
      for (int j = 0; j < m; j++)
        check($sformatf("%s_u%0d_beat%0d", tag, i, j), mon_q[i][j], exp_q[i][j]);
      mon_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  function automatic int count_good(input int i);
    int c;
    c = 0;
    foreach (mon_q[i][j]) if (mon_q[i][j][9]) c++;
    return c;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bq_t tv;
    bq_t b;
    int l;
    rst = 1'b1;
    dv  = 1'b0;
    er  = 1'b0;
    rxd = 4'h0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset_init");
    rst = 1'b0;
    idle(2);

    // 13-byte "123456789" frame with a correct FCS.
    tv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(tv, -1, 1'b0, 0, -1);
    idle(3);
    check("tp_good_beats", mon_q[1].size(), 9);
    if (mon_q[1].size() == 9) check("tp_good_last", mon_q[1][8][11:0], 12'hE39);
    compare_all("tp_good");

    // Corrupted FCS.
    b = tv;
    b[12] = 8'hCA;
    send_frame(b, -1, 1'b0, 0, -1);
    idle(3);
    compare_all("tp_badfcs");

    // 3-byte frame: lone bad pulse.
    send_frame(rand_bytes(3), -1, 1'b0, 0, -1);
    idle(3);
    compare_all("tp_short");

    // Receive error during byte 4, then a dribble nibble.
    send_frame(tv, 4, 1'b0, 0, -1);
    idle(3);
    compare_all("tp_rxer");
    send_frame(tv, -1, 1'b1, 0, -1);
    idle(3);
    compare_all("tp_dribble");

    // 30-byte valid frame: oversize on the MAX_LEN=20 instance only.
    send_frame(with_fcs(rand_bytes(26)), -1, 1'b0, 0, -1);
    idle(3);
    check("tp_ovf_beats", mon_q[2].size(), 16);
    if (mon_q[2].size() == 16) check("tp_ovf_last", mon_q[2][15][11:8], 4'b1101);
    compare_all("tp_ovf");
    send_frame(tv, -1, 1'b0, 0, -1);
    idle(3);
    compare_all("tp_after_ovf");

    // Back-to-back frames, then a reset midway through a third.
    send_frame(tv, -1, 1'b0, 0, -1);
    send_frame(with_fcs(rand_bytes(20)), -1, 1'b0, 0, -1);
    send_frame(tv, -1, 1'b0, 0, 4);
    idle(3);
    check("tp_b2b_goods", count_good(1), 2);
    compare_all("tp_b2b_rst");
    send_frame(tv, -1, 1'b0, 0, -1);
    idle(3);
    compare_all("tp_after_rst");

    // Random frames.
    for (int t = 0; t < 30; t++) begin
      int kind;
      int sel;
      kind = 0;
      sel = $urandom_range(0, 9);
      if (sel == 0) kind = 1;
      else if (sel == 1) kind = 2;
      l = $urandom_range(1, 70);
      if (l > 4 && $urandom_range(0, 3) != 0) b = with_fcs(rand_bytes(l - 4));
      else b = rand_bytes(l);
      send_frame(b, ($urandom_range(0, 7) == 0) ? $urandom_range(0, l - 1) : -1,
                 $urandom_range(0, 7) == 0, kind, -1);
      idle($urandom_range(2, 4));
      compare_all($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
